// File: rtl/spi_ram_arb_pkg.sv
// Shared types and opcode encodings for the SPI/host RAM arbiter.
// Imported by the top level and the round-robin sub-block.
package spi_ram_arb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StRdWait = 2'd2
    } state_e;

    localparam logic [1:0] OP_WADDR = 2'b00;
    localparam logic [1:0] OP_WDATA = 2'b01;
    localparam logic [1:0] OP_RADDR = 2'b10;
    localparam logic [1:0] OP_RDATA = 2'b11;

    function automatic logic is_data_op(input logic [1:0] op);
        return (op == OP_WDATA) || (op == OP_RDATA);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant with a last-served marker.
// Requester 0 is the SPI side, requester 1 the host; reset favours requester 0 on the first tie.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_take,
    output logic o_gnt0,
    output logic o_gnt1
);

    logic r_last1;

    always_comb begin
        o_gnt0 = 1'b0;
        o_gnt1 = 1'b0;
        if (i_req0 && i_req1) begin
            o_gnt0 = r_last1;
            o_gnt1 = !r_last1;
        end else begin
            o_gnt0 = i_req0;
            o_gnt1 = i_req1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last1 <= 1'b1;
        end else if (i_take && (o_gnt0 || o_gnt1)) begin
            r_last1 <= o_gnt1;
        end
    end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Arbitrates a single-port RAM between an SPI command stream and a host request port.
// SPI data commands go through a one-entry pending register; all outputs are registered.
module spi_ram_arbiter
    import spi_ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W+1:0] spi_rx_data,
    input  logic              spi_rx_valid,
    output logic [DATA_W-1:0] spi_tx_data,
    output logic              spi_tx_valid,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              err_ovf
);

    state_e r_state, w_state_next;

    logic [ADDR_W-1:0] r_wr_addr, r_rd_addr;
    logic              r_pend_vld, r_pend_we;
    logic [ADDR_W-1:0] r_pend_addr;
    logic [DATA_W-1:0] r_pend_data;
    logic              r_err_ovf;

    logic              r_win_host, w_win_host;
    logic              r_ram_en, w_ram_en;
    logic              r_ram_we, w_ram_we;
    logic [ADDR_W-1:0] r_ram_addr, w_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata, w_ram_wdata;
    logic              r_host_gnt, w_host_gnt;
    logic              r_spi_tx_valid, w_spi_tx_valid;
    logic              r_host_rvalid, w_host_rvalid;
    logic [DATA_W-1:0] r_spi_tx_data, r_host_rdata;

    logic [1:0]        w_op;
    logic [ADDR_W-1:0] w_payload;
    logic              w_idle, w_consume, w_is_data, w_accept, w_ovf;
    logic              w_spi_req, w_host_req, w_gnt_spi, w_gnt_host;

    assign w_op      = spi_rx_data[ADDR_W+1:ADDR_W];
    assign w_payload = spi_rx_data[ADDR_W-1:0];
    assign w_idle    = (r_state == StIdle);
    // The pending entry is released during the ACCESS cycle it was issued in.
    assign w_consume = (r_state == StAccess) && !r_win_host;
    assign w_is_data = spi_rx_valid && is_data_op(w_op);
    assign w_accept  = w_is_data && (!r_pend_vld || w_consume);
    assign w_ovf     = w_is_data && r_pend_vld && !w_consume;

    assign w_spi_req  = w_idle && r_pend_vld;
    assign w_host_req = w_idle && host_req;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .i_req0 (w_spi_req),
        .i_req1 (w_host_req),
        .i_take (w_idle),
        .o_gnt0 (w_gnt_spi),
        .o_gnt1 (w_gnt_host)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_addr   <= '0;
            r_rd_addr   <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_we   <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= '0;
            r_err_ovf   <= 1'b0;
        end else begin
            if (spi_rx_valid && (w_op == OP_WADDR)) begin
                r_wr_addr <= w_payload;
            end
            if (spi_rx_valid && (w_op == OP_RADDR)) begin
                r_rd_addr <= w_payload;
            end
            if (w_consume) begin
                r_pend_vld <= 1'b0;
            end
            if (w_accept) begin
                r_pend_vld  <= 1'b1;
                r_pend_we   <= (w_op == OP_WDATA);
                r_pend_addr <= (w_op == OP_WDATA) ? r_wr_addr : r_rd_addr;
                r_pend_data <= DATA_W'(w_payload);
            end
            if (w_ovf) begin
                r_err_ovf <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_win_host     = r_win_host;
        w_ram_en       = 1'b0;
        w_ram_we       = 1'b0;
        w_ram_addr     = '0;
        w_ram_wdata    = '0;
        w_host_gnt     = 1'b0;
        w_spi_tx_valid = 1'b0;
        w_host_rvalid  = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_gnt_spi) begin
                    w_state_next = StAccess;
                    w_win_host   = 1'b0;
                    w_ram_en     = 1'b1;
                    w_ram_we     = r_pend_we;
                    w_ram_addr   = r_pend_addr;
                    w_ram_wdata  = r_pend_data;
                end else if (w_gnt_host) begin
                    w_state_next = StAccess;
                    w_win_host   = 1'b1;
                    w_ram_en     = 1'b1;
                    w_ram_we     = host_we;
                    w_ram_addr   = host_addr;
                    w_ram_wdata  = host_wdata;
                    w_host_gnt   = 1'b1;
                end
            end
            StAccess: begin
                w_state_next = r_ram_we ? StIdle : StRdWait;
            end
            StRdWait: begin
                w_state_next   = StIdle;
                w_spi_tx_valid = !r_win_host;
                w_host_rvalid  = r_win_host;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= StIdle;
            r_win_host     <= 1'b0;
            r_ram_en       <= 1'b0;
            r_ram_we       <= 1'b0;
            r_ram_addr     <= '0;
            r_ram_wdata    <= '0;
            r_host_gnt     <= 1'b0;
            r_spi_tx_valid <= 1'b0;
            r_host_rvalid  <= 1'b0;
            r_spi_tx_data  <= '0;
            r_host_rdata   <= '0;
        end else begin
            r_state        <= w_state_next;
            r_win_host     <= w_win_host;
            r_ram_en       <= w_ram_en;
            r_ram_we       <= w_ram_we;
            r_ram_addr     <= w_ram_addr;
            r_ram_wdata    <= w_ram_wdata;
            r_host_gnt     <= w_host_gnt;
            r_spi_tx_valid <= w_spi_tx_valid;
            r_host_rvalid  <= w_host_rvalid;
            if ((r_state == StRdWait) && !r_win_host) begin
                r_spi_tx_data <= ram_rdata;
            end
            if ((r_state == StRdWait) && r_win_host) begin
                r_host_rdata <= ram_rdata;
            end
        end
    end

    assign spi_tx_data  = r_spi_tx_data;
    assign spi_tx_valid = r_spi_tx_valid;
    assign host_gnt     = r_host_gnt;
    assign host_rdata   = r_host_rdata;
    assign host_rvalid  = r_host_rvalid;
    assign ram_en       = r_ram_en;
    assign ram_we       = r_ram_we;
    assign ram_addr     = r_ram_addr;
    assign ram_wdata    = r_ram_wdata;
    assign err_ovf      = r_err_ovf;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Self-checking bench for spi_ram_arbiter: table-driven SPI transfers plus contention,
// overflow and reset corner cases, with read data scored through expectation queues.
module tb_spi_ram_arbiter;

    logic       clk;
    logic       rst;
    logic [9:0] spi_rx_data;
    logic       spi_rx_valid;
    logic [7:0] spi_tx_data;
    logic       spi_tx_valid;
    logic       host_req;
    logic       host_we;
    logic [7:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_gnt;
    logic [7:0] host_rdata;
    logic       host_rvalid;
    logic       ram_en;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic       err_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] spi_q[$];
    logic [7:0] host_q[$];
    logic [7:0] mem[256];

    typedef struct {
        logic       rd;
        logic [7:0] addr;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[9];

    spi_ram_arbiter #(
        .ADDR_W (8),
        .DATA_W (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .spi_rx_data  (spi_rx_data),
        .spi_rx_valid (spi_rx_valid),
        .spi_tx_data  (spi_tx_data),
        .spi_tx_valid (spi_tx_valid),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_gnt     (host_gnt),
        .host_rdata   (host_rdata),
        .host_rvalid  (host_rvalid),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .err_ovf      (err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: read data appears the cycle after the enable.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (spi_tx_valid === 1'b1) begin
            if (spi_q.size() == 0) chk("spi_tx_unexpected", 32'(spi_tx_valid), 0);
            else                   chk("spi_tx_data", 32'(spi_tx_data), 32'(spi_q.pop_front()));
        end
        if (host_rvalid === 1'b1) begin
            if (host_q.size() == 0) chk("host_rvalid_unexpected", 32'(host_rvalid), 0);
            else                    chk("host_rdata", 32'(host_rdata), 32'(host_q.pop_front()));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic spi_cmd(input logic [1:0] op, input logic [7:0] pl);
        spi_rx_data  = {op, pl};
        spi_rx_valid = 1'b1;
        cyc();
        spi_rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        spi_rx_valid = 1'b0;
        host_req = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ram_en"},  32'(ram_en), 0);
        chk({tag, "_ram_bus"}, 32'({ram_we, ram_addr, ram_wdata}), 0);
        chk({tag, "_spi_tx"},  32'({spi_tx_valid, spi_tx_data}), 0);
        chk({tag, "_host"},    32'({host_gnt, host_rvalid, host_rdata}), 0);
        chk({tag, "_err_ovf"}, 32'(err_ovf), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'h5A;
        mem[8'h30] = 8'h9C;
        mem[8'h31] = 8'h4B;
        ram_rdata    = 8'h00;
        spi_rx_data  = '0;
        spi_rx_valid = 1'b0;
        host_req     = 1'b0;
        host_we      = 1'b0;
        host_addr    = '0;
        host_wdata   = '0;

        vecs[0] = '{1'b0, 8'h12, 8'hA5};
        vecs[1] = '{1'b1, 8'h12, 8'hA5};
        vecs[2] = '{1'b0, 8'hFF, 8'h3C};
        vecs[3] = '{1'b0, 8'h00, 8'hC3};
        vecs[4] = '{1'b1, 8'hFF, 8'h3C};
        vecs[5] = '{1'b1, 8'h00, 8'hC3};
        vecs[6] = '{1'b0, 8'h12, 8'h5A};
        vecs[7] = '{1'b1, 8'h12, 8'h5A};
        vecs[8] = '{1'b1, 8'h30, 8'h9C};

        do_reset();
        chk_all_zero("reset");

        // Table: address command, then data command; ram_en lands at N+2, read strobe at N+4.
        foreach (vecs[i]) begin
            spi_cmd(vecs[i].rd ? 2'b10 : 2'b00, vecs[i].addr);
            if (vecs[i].rd) spi_q.push_back(vecs[i].data);
            spi_cmd(vecs[i].rd ? 2'b11 : 2'b01, vecs[i].rd ? 8'h00 : vecs[i].data);
            chk($sformatf("v%0d_en_n1", i), 32'(ram_en), 0);
            cyc();
            chk($sformatf("v%0d_en_n2", i), 32'(ram_en), 1);
            chk($sformatf("v%0d_we", i), 32'(ram_we), 32'(!vecs[i].rd));
            chk($sformatf("v%0d_addr", i), 32'(ram_addr), 32'(vecs[i].addr));
            if (!vecs[i].rd) chk($sformatf("v%0d_wdata", i), 32'(ram_wdata), 32'(vecs[i].data));
            cyc();
            chk($sformatf("v%0d_en_n3", i), 32'(ram_en), 0);
            if (vecs[i].rd) begin
                chk($sformatf("v%0d_txv_n3", i), 32'(spi_tx_valid), 0);
                cyc();
                chk($sformatf("v%0d_txv_n4", i), 32'(spi_tx_valid), 1);
            end
            cyc();
            cyc();
        end

        // Tie after reset: SPI write wins, host read follows at the next IDLE decision.
        do_reset();
        spi_cmd(2'b00, 8'h40);
        spi_cmd(2'b01, 8'h77);
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 8'h30;
        host_q.push_back(8'h9C);
        cyc();
        chk("tie_spi_en", 32'({ram_en, ram_we, ram_addr, ram_wdata}), 32'({2'b11, 8'h40, 8'h77}));
        chk("tie_no_gnt", 32'(host_gnt), 0);
        cyc();
        chk("tie_gap", 32'({ram_en, host_gnt}), 0);
        cyc();
        chk("tie_host_gnt", 32'(host_gnt), 1);
        chk("tie_host_en", 32'({ram_en, ram_we, ram_addr}), 32'({2'b10, 8'h30}));
        host_req = 1'b0;
        cyc();
        chk("tie_gnt_pulse", 32'({host_gnt, host_rvalid}), 0);
        cyc();
        chk("tie_rvalid", 32'(host_rvalid), 1);
        cyc();
        chk("tie_rvalid_pulse", 32'(host_rvalid), 0);

        // Second data command while the first is still pending behind a host read.
        do_reset();
        spi_cmd(2'b00, 8'h55);
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 8'h31;
        host_q.push_back(8'h4B);
        cyc();
        chk("ovf_host_gnt", 32'(host_gnt), 1);
        host_req     = 1'b0;
        spi_rx_data  = {2'b01, 8'h11};
        spi_rx_valid = 1'b1;
        cyc();
        chk("ovf_before", 32'(err_ovf), 0);
        spi_rx_data  = {2'b01, 8'h22};
        cyc();
        spi_rx_valid = 1'b0;
        chk("ovf_set", 32'(err_ovf), 1);
        chk("ovf_host_rvalid", 32'(host_rvalid), 1);
        cyc();
        chk("ovf_first_kept", 32'({ram_en, ram_we, ram_addr, ram_wdata}),
            32'({2'b11, 8'h55, 8'h11}));
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk($sformatf("ovf_no_second_%0d", k), 32'(ram_en), 0);
            chk($sformatf("ovf_sticky_%0d", k), 32'(err_ovf), 1);
        end
        do_reset();
        chk("ovf_cleared", 32'(err_ovf), 0);

        // Reload in the consume cycle is accepted without overflow.
        spi_cmd(2'b00, 8'h60);
        spi_cmd(2'b01, 8'h01);
        cyc();
        chk("reload_first", 32'({ram_en, ram_wdata}), 32'({1'b1, 8'h01}));
        spi_rx_data  = {2'b01, 8'h02};
        spi_rx_valid = 1'b1;
        cyc();
        spi_rx_valid = 1'b0;
        chk("reload_gap", 32'({ram_en, err_ovf}), 0);
        cyc();
        chk("reload_second", 32'({ram_en, ram_we, ram_addr, ram_wdata}),
            32'({2'b11, 8'h60, 8'h02}));
        chk("reload_no_ovf", 32'(err_ovf), 0);
        cyc();
        cyc();

        // Reset during RDWAIT of an SPI read drops the read.
        spi_cmd(2'b10, 8'h12);
        spi_cmd(2'b11, 8'h00);
        cyc();
        chk("rstrd_en", 32'({ram_en, ram_we}), 32'(2'b10));
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_all_zero("rstrd");
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk($sformatf("rstrd_no_txv_%0d", k), 32'(spi_tx_valid), 0);
        end
        spi_cmd(2'b00, 8'h66);
        spi_cmd(2'b01, 8'hEE);
        cyc();
        chk("rstrd_write_after", 32'({ram_en, ram_we, ram_addr, ram_wdata}),
            32'({2'b11, 8'h66, 8'hEE}));
        cyc();
        cyc();

        chk("spi_q_drained", 32'(spi_q.size()), 0);
        chk("host_q_drained", 32'(host_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
